// File: rtl/alu_arbiter_if.sv
// Bus bundle for the two-requester ALU arbiter: two request channels and
// one response channel, each with a valid/ready handshake.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [63:0] req0_a;
    logic [63:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [63:0] req1_a;
    logic [63:0] req1_b;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [63:0] resp_out;
    logic        resp_flag;

    // Requester/consumer side: drives operations, takes responses.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_out, resp_flag
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_out, resp_flag
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one combinational 64-bit ALU (add/sub/and/xor).
// The winner's result is captured in a one-entry response register; the
// buffer accepts a new operation whenever it is empty or being drained in
// the same cycle, so back-to-back traffic flows without bubbles.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1   // 1: round-robin, 0: requester 0 always wins
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    typedef struct packed {
        logic [63:0] out;
        logic        flag;
    } alu_res_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Shared ALU. Add and subtract both run through a 65-bit datapath so
    // bit 64 is the carry (add) or the borrow (sub).
    function automatic alu_res_t alu_calc(input logic [1:0]  op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        alu_res_t    r;
        logic [64:0] wide;
        r    = '0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                r.out  = wide[63:0];
                r.flag = wide[64];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                r.out  = wide[63:0];
                r.flag = wide[64];
            end
            OP_AND: r.out = a & b;
            OP_XOR: r.out = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic        last_q, last_d;          // requester granted at last accepted transfer
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [63:0] resp_out_q, resp_out_d;
    logic        resp_flag_q, resp_flag_d;

    logic        buf_free;
    logic        rr_pick1;
    logic        gnt0, gnt1;
    logic        accept;
    logic [1:0]  sel_op;
    logic [63:0] sel_a, sel_b;
    alu_res_t    alu_res;

    // Grant logic: depends only on valids, state, resp_ready and the pointer,
    // never on operands, so readys cannot loop back through the ALU.
    always_comb begin
        buf_free = (state_q == EMPTY) || bus.resp_ready;
        // Under contention in round-robin mode, requester 1 wins only if
        // requester 0 took the last transfer.
        rr_pick1 = RR_EN && (last_q == 1'b0);
        gnt0     = !rst && buf_free && bus.req0_valid
                   && !(bus.req1_valid && rr_pick1);
        gnt1     = !rst && buf_free && bus.req1_valid
                   && !(bus.req0_valid && !rr_pick1);
        accept   = gnt0 || gnt1;
    end

    // Operand mux feeding the single shared ALU.
    always_comb begin
        sel_op  = gnt1 ? bus.req1_op : bus.req0_op;
        sel_a   = gnt1 ? bus.req1_a  : bus.req0_a;
        sel_b   = gnt1 ? bus.req1_b  : bus.req0_b;
        alu_res = alu_calc(sel_op, sel_a, sel_b);
    end

    // Next-state: load on accept (covers drain+accept with no bubble),
    // otherwise empty the buffer when it drains.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_flag_d  = resp_flag_q;
        if (accept) begin
            state_d      = FULL;
            last_d       = gnt1;
            resp_valid_d = 1'b1;
            resp_id_d    = gnt1;
            resp_out_d   = alu_res.out;
            resp_flag_d  = alu_res.flag;
        end else if (state_q == FULL && bus.resp_ready) begin
            state_d      = EMPTY;
            resp_valid_d = 1'b0;
        end
    end

    // State and registered outputs; reset discards any held response at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_out_q   <= '0;
            resp_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
            resp_flag_q  <= resp_flag_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_out   = resp_out_q;
    assign bus.resp_flag  = resp_flag_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_op / req1_op  input  2  opcode: 00 add, 01 subtract, 10 AND, 11 XOR.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  64  operands.
REQ-008 resp_valid  output  1  response register holds a result.
REQ-009 resp_ready  input  1  consumer takes the response this cycle.
REQ-010 resp_id  output  1  index of the requester that owns the response.
REQ-011 resp_out  output  64  registered ALU result.
REQ-012 resp_flag  output  1  registered ALU flag.

Function
REQ-013 The block SHALL share one combinational 64-bit ALU (add/sub/and/xor) between two requesters, with a one-entry registered response buffer.
REQ-014 The state machine SHALL have two states: EMPTY (no response held) and FULL (response held).
REQ-015 The buffer SHALL be free in a cycle when state is EMPTY, or when state is FULL and resp_ready=1.
REQ-016 The arbiter SHALL assert at most one reqN_ready per cycle: the grant, asserted only if the buffer is free and that requester's valid=1.
REQ-017 If exactly one requester is valid, it SHALL receive the grant.
REQ-018 If both are valid and RR_EN=1, the grant SHALL go to the requester not granted at the last accepted transfer; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-019 If both are valid and RR_EN=0, requester 0 SHALL always win.
REQ-020 The last-grant pointer SHALL update only on an accepted transfer (valid and ready both 1).
REQ-021 On an accepted transfer at edge N, resp_out, resp_flag and resp_id SHALL be loaded at edge N, and resp_valid SHALL be 1 from cycle N+1 (latency 1).
REQ-022 resp_out, resp_flag and resp_id SHALL remain stable while resp_valid=1 and resp_ready=0.
REQ-023 Simultaneous drain and accept (FULL, resp_ready=1, new grant) SHALL replace the buffer contents with no bubble, and state SHALL stay FULL.
REQ-024 Drain without accept SHALL move state FULL to EMPTY; resp_valid SHALL be 0 from the next cycle.
REQ-025 Arithmetic is 64-bit modulo 2^64.
REQ-026 add: out=a+b, flag=carry out of bit 63.
REQ-027 sub: out=a-b, flag=1 if a<b unsigned (borrow).
REQ-028 AND/XOR: bitwise result, flag=0.
REQ-029 reqN_ready SHALL NOT depend on the other requester's operands or opcode, only on valids, state, resp_ready and the pointer.
REQ-030 A requester may hold valid across cycles; its operands SHALL be sampled only in the cycle of acceptance.

Reset
REQ-031 While rst=1: state=EMPTY, resp_valid=0, resp_out=0, resp_flag=0, resp_id=0, pointer=1, req0_ready=0, req1_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard any held response immediately (asynchronously); no response SHALL be emitted for it after reset release.
REQ-033 The first grant SHALL be possible in the first clock cycle after rst deasserts.

Verification
REQ-034 Single add: req0 op=00, a=0xFFFF_FFFF_FFFF_FFFF, b=1, resp_ready=1 -> next cycle resp_valid=1, resp_out=0, resp_flag=1, resp_id=0.
REQ-035 Subtract borrow: req1 op=01, a=3, b=5 -> resp_out=0xFFFF_FFFF_FFFF_FFFE, resp_flag=1, resp_id=1; with a=5, b=3 -> resp_out=2, flag=0.
REQ-036 Contention, RR_EN=1: both valid continuously for 4 ops, resp_ready=1 -> resp_id sequence 0,1,0,1, one response per cycle, no bubbles.
REQ-037 Backpressure: resp_ready=0 for 3 cycles with the buffer FULL -> both readys=0, resp_out/flag/id unchanged; resp_ready=1 -> the pending grant is accepted in the same cycle.
REQ-038 Reset mid-operation: rst pulsed while FULL holding 0x1234 -> resp_valid=0 immediately; after release with no requests, resp_valid stays 0.
REQ-039 Fixed priority, RR_EN=0: both valid for 3 ops -> resp_id 0,0,0; req1 is granted only after req0_valid drops.
